// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// Optional build macro used by this slice: RISCV_ARB_ROUND_ROBIN_EN.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int CNT_W_DEF          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for the arbiter: I-port, D-port and backing-memory signals.
// slave  = arbiter view (takes requests, drives grants and the memory side).
// master = environment view (cache miss logic plus the memory model).
interface riscv_mem_arbiter_if
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/riscv_mem_arbiter_pick.sv
// Combinational winner selection between the I and D ports.
// RISCV_ARB_ROUND_ROBIN_EN defined: on a conflict the port not granted last wins.
// Undefined: D always beats I and last_grant is ignored.
module riscv_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    assign any_req = i_req | d_req;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
    // Single requester wins outright; a conflict goes to the port not served last.
    always_comb begin
        winner = d_req ? PORT_D : PORT_I;
        if (i_req && d_req) begin
            winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign winner = d_req ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between I-cache refill and D-cache accesses.
// Registered req/gnt/valid handshake with a per-access timeout watchdog.
// Build macro RISCV_ARB_ROUND_ROBIN_EN selects round-robin instead of D-first.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    riscv_mem_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              expired;
    logic              any_req, winner, last_grant;

    logic              i_gnt_q, i_gnt_d, i_valid_q, i_valid_d, i_err_q, i_err_d;
    logic              d_gnt_q, d_gnt_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    riscv_arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

`ifdef RISCV_ARB_ROUND_ROBIN_EN
    // Remember which port was granted last; starts at I so D takes the first conflict.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= PORT_I;
        end else if (state_q == ST_IDLE && any_req) begin
            last_grant <= winner;
        end
    end
`else
    assign last_grant = PORT_I;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);
    // The watchdog fires on the BUSY cycle that brings the count up to the limit.
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Next-state and next-output logic; pulses default low, latches default to hold.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    mem_en_d = 1'b1;
                    if (winner == PORT_D) begin
                        state_d     = ST_BUSY_D;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        state_d     = ST_BUSY_I;
                        i_gnt_d     = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                cnt_d = cnt_inc;
                // A ready in the expiry cycle wins over the timeout.
                if (bus.mem_ready || expired) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == ST_BUSY_I) begin
                        i_valid_d = 1'b1;
                        i_err_d   = !bus.mem_ready;
                        i_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = !bus.mem_ready;
                        d_rdata_d = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State, counter and every registered output; reset drops any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.i_gnt     = i_gnt_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter (watchdog limit set to 4 cycles).
// Expectations for the second conflict depend on RISCV_ARB_ROUND_ROBIN_EN.
module tb_riscv_mem_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    riscv_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Snapshot of every DUT output, used for all-zero checks.
    function automatic logic [135:0] all_outs();
        return {bus.i_gnt, bus.i_valid, bus.i_err, bus.d_gnt, bus.d_valid, bus.d_err,
                bus.mem_en, bus.mem_we, bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if (all_outs() !== 136'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", all_outs());
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        tick();
        total++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_addr} !== {1'b1, 1'b1, 32'h80}) begin
            bad++;
            $display("FAIL mid_gnt got=%h want=%h", {bus.d_gnt, bus.mem_en, bus.mem_addr}, {1'b1, 1'b1, 32'h80});
        end
        bus.d_req = 1'b0;
        tick();
        #1 reset = 1'b1;
        #1;
        total++;
        if (all_outs() !== 136'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h want=0", all_outs());
        end
        #1 reset = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if ({bus.d_valid, bus.i_valid, bus.mem_en} !== 3'b000) begin
                bad++;
                $display("FAIL mid_no_valid got=%b want=000", {bus.d_valid, bus.i_valid, bus.mem_en});
            end
        end
        bus.mem_ready = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        tick();
        total++;
        if ({bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h20}) begin
            bad++;
            $display("FAIL mid_after_igng got=%h want=%h", {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_addr}, {1'b1, 1'b0, 1'b1, 32'h20});
        end
        bus.i_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11;
        tick();
        total++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata} !== {1'b1, 1'b0, 32'h11}) begin
            bad++;
            $display("FAIL mid_after_ivalid got=%h want=%h", {bus.i_valid, bus.i_err, bus.i_rdata}, {1'b1, 1'b0, 32'h11});
        end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_i_fetch();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
        tick();
        total++;
        if ({bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {4'b1010, 32'h10}) begin
            bad++;
            $display("FAIL fetch_gnt got=%h want=%h", {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}, {4'b1010, 32'h10});
        end
        bus.i_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0093;
        tick();
        total++;
        if ({bus.i_valid, bus.i_err, bus.i_gnt, bus.mem_en} !== 4'b1000) begin
            bad++;
            $display("FAIL fetch_valid got=%b want=1000", {bus.i_valid, bus.i_err, bus.i_gnt, bus.mem_en});
        end
        total++;
        if (bus.i_rdata !== 32'h93) begin
            bad++;
            $display("FAIL fetch_rdata got=%h want=%h", bus.i_rdata, 32'h93);
        end
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        tick();
        total++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata} !== {2'b00, 32'h93}) begin
            bad++;
            $display("FAIL fetch_hold got=%h want=%h", {bus.i_valid, bus.i_err, bus.i_rdata}, {2'b00, 32'h93});
        end
    endtask

    task automatic test_conflict();
        logic rr;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        tick();
        total++;
        if ({bus.d_gnt, bus.i_gnt, bus.mem_addr} !== {2'b10, 32'h200}) begin
            bad++;
            $display("FAIL conflict1_gnt got=%h want=%h", {bus.d_gnt, bus.i_gnt, bus.mem_addr}, {2'b10, 32'h200});
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55;
        tick();
        total++;
        if ({bus.d_valid, bus.d_err, bus.i_gnt, bus.d_gnt, bus.d_rdata} !== {4'b1000, 32'h55}) begin
            bad++;
            $display("FAIL conflict1_valid got=%h want=%h", {bus.d_valid, bus.d_err, bus.i_gnt, bus.d_gnt, bus.d_rdata}, {4'b1000, 32'h55});
        end
        bus.mem_ready = 1'b0;
        tick();
        total++;
        if ({bus.i_gnt, bus.d_gnt, bus.mem_addr} !== (rr ? {2'b10, 32'h100} : {2'b01, 32'h200})) begin
            bad++;
            $display("FAIL conflict2_gnt got=%h want=%h", {bus.i_gnt, bus.d_gnt, bus.mem_addr}, (rr ? {2'b10, 32'h100} : {2'b01, 32'h200}));
        end
        if (rr) bus.i_req = 1'b0; else bus.d_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h66;
        tick();
        total++;
        if ({bus.i_valid, bus.d_valid} !== (rr ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL conflict2_valid got=%b want=%b", {bus.i_valid, bus.d_valid}, (rr ? 2'b10 : 2'b01));
        end
        bus.mem_ready = 1'b0;
        tick();
        total++;
        if ({bus.i_gnt, bus.d_gnt, bus.mem_addr} !== (rr ? {2'b01, 32'h200} : {2'b10, 32'h100})) begin
            bad++;
            $display("FAIL conflict3_gnt got=%h want=%h", {bus.i_gnt, bus.d_gnt, bus.mem_addr}, (rr ? {2'b01, 32'h200} : {2'b10, 32'h100}));
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        tick();
        total++;
        if ({bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata} !==
            (rr ? {2'b01, 32'h66, 32'h77} : {2'b10, 32'h77, 32'h66})) begin
            bad++;
            $display("FAIL conflict3_valid got=%h want=%h", {bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata},
                     (rr ? {2'b01, 32'h66, 32'h77} : {2'b10, 32'h77, 32'h66}));
        end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        total++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 32'h40, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL store_gnt got=%h want=%h", {bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {3'b111, 32'h40, 32'hDEAD_BEEF});
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h99; bus.d_wdata = 32'h0;
        tick();
        total++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b011, 32'h40, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL store_stable got=%h want=%h", {bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {3'b011, 32'h40, 32'hDEAD_BEEF});
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234;
        tick();
        total++;
        if ({bus.d_valid, bus.d_err, bus.mem_en, bus.mem_we, bus.d_rdata} !== {4'b1000, 32'h0}) begin
            bad++;
            $display("FAIL store_valid got=%h want=%h", {bus.d_valid, bus.d_err, bus.mem_en, bus.mem_we, bus.d_rdata}, {4'b1000, 32'h0});
        end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_ready_at_expiry();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h304;
        tick();
        total++;
        if ({bus.d_gnt, bus.mem_en} !== 2'b11) begin
            bad++;
            $display("FAIL expiry_gnt got=%b want=11", {bus.d_gnt, bus.mem_en});
        end
        bus.d_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if ({bus.d_valid, bus.mem_en} !== 2'b01) begin
                bad++;
                $display("FAIL expiry_wait%0d got=%b want=01", n, {bus.d_valid, bus.mem_en});
            end
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_ABCD;
        tick();
        total++;
        if ({bus.d_valid, bus.d_err, bus.mem_en, bus.d_rdata} !== {3'b100, 32'hABCD}) begin
            bad++;
            $display("FAIL expiry_ready_wins got=%h want=%h", {bus.d_valid, bus.d_err, bus.mem_en, bus.d_rdata}, {3'b100, 32'hABCD});
        end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        tick();
        total++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_addr} !== {2'b11, 32'h300}) begin
            bad++;
            $display("FAIL timeout_gnt got=%h want=%h", {bus.d_gnt, bus.mem_en, bus.mem_addr}, {2'b11, 32'h300});
        end
        bus.d_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if ({bus.d_valid, bus.d_err, bus.mem_en} !== 3'b001) begin
                bad++;
                $display("FAIL timeout_wait%0d got=%b want=001", n, {bus.d_valid, bus.d_err, bus.mem_en});
            end
        end
        tick();
        total++;
        if ({bus.d_valid, bus.d_err, bus.mem_en, bus.d_rdata} !== {3'b110, 32'h0}) begin
            bad++;
            $display("FAIL timeout_fire got=%h want=%h", {bus.d_valid, bus.d_err, bus.mem_en, bus.d_rdata}, {3'b110, 32'h0});
        end
        tick();
        total++;
        if ({bus.d_valid, bus.d_err, bus.mem_en} !== 3'b000) begin
            bad++;
            $display("FAIL timeout_after got=%b want=000", {bus.d_valid, bus.d_err, bus.mem_en});
        end
    endtask

    task automatic test_stray_ready();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFF;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if ({bus.i_valid, bus.d_valid, bus.i_gnt, bus.d_gnt, bus.mem_en} !== 5'b00000) begin
                bad++;
                $display("FAIL stray_ready%0d got=%b want=00000", n, {bus.i_valid, bus.d_valid, bus.i_gnt, bus.d_gnt, bus.mem_en});
            end
        end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_reset_mid_access();
        test_i_fetch();
        test_conflict();
        test_store();
        test_ready_at_expiry();
        test_timeout();
        test_stray_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule
